// File: rtl/npu_spi_pkg.sv
// Shared definitions for the NPU SPI command-link master.
// Frame layout, FSM state encoding and the frame packing helper.
package npu_spi_pkg;

  localparam int FRAME_BITS   = 24;
  localparam int RX_FIRST_BIT = 8;
  localparam int RX_LAST_BIT  = 15;

  localparam int CMD_LSB  = 16;
  localparam int TI_LSB   = 13;
  localparam int TJ_LSB   = 10;
  localparam int OP_LSB   = 8;
  localparam int DATA_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HI,
    S_LO,
    S_GAP
  } spi_mst_state_e;

  // op_code[0] is recovered by the slave from data[7]
  function automatic logic [FRAME_BITS-1:0] pack_frame(
    input logic [7:0] cmd,
    input logic [2:0] tile_i,
    input logic [2:0] tile_j,
    input logic [2:0] op_code,
    input logic [7:0] data
  );
    logic [FRAME_BITS-1:0] f;
    logic                  unused_op0;
    unused_op0 = op_code[0];
    f = '0;
    f[CMD_LSB  +: 8] = cmd;
    f[TI_LSB   +: 3] = tile_i;
    f[TJ_LSB   +: 3] = tile_j;
    f[OP_LSB   +: 2] = op_code[2:1];
    f[DATA_LSB +: 8] = data;
    return f;
  endfunction

endpackage

// File: rtl/npu_spi_phase_timer.sv
// Loadable down-counter; tick_o is high while the count is zero.
// A phase loaded with N lasts N+1 cycles.
module npu_spi_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tick_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/npu_spi_master.sv
// SPI mode-0 master sending one 24-bit NPU command frame, MSB first.
// Define NPU_SPI_ABORT_EN to add the abort/aborted frame-cancel ports.
module npu_spi_master
  import npu_spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] cmd,
  input  logic [2:0] tile_i,
  input  logic [2:0] tile_j,
  input  logic [2:0] op_code,
  input  logic [7:0] data,
  output logic       ready,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       sclk,
  output logic       mosi,
  output logic       cs_n,
`ifdef NPU_SPI_ABORT_EN
  input  logic       abort,
  output logic       aborted,
`endif
  input  logic       miso
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [4:0] LAST = 5'(FRAME_BITS - 1);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("CLK_DIV must be >= 1");
  end

  spi_mst_state_e state_q, state_d;
  logic [FRAME_BITS-1:0] tx_q;
  logic [4:0]  bit_q, bit_d;
  logic        mosi_q;
  logic [7:0]  rx_q;
  logic        done_q;
  logic        load;
  logic [CW-1:0] load_val;
  logic        tick;
  logic        accept;
  logic        abort_hit;
  logic        rx_hit;
  logic [2:0]  rx_idx;
  logic [FRAME_BITS-1:0] frame;

  assign frame  = pack_frame(cmd, tile_i, tile_j, op_code, data);
  assign accept = (state_q == S_IDLE) && start;

`ifdef NPU_SPI_ABORT_EN
  logic ab_q;
  assign abort_hit = abort &&
    (state_q inside {S_SETUP, S_HI, S_LO});
  assign aborted = ab_q;
`else
  assign abort_hit = 1'b0;
`endif

  npu_spi_phase_timer #(.W(CW)) u_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (load),
    .load_val_i (load_val),
    .tick_o     (tick)
  );

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    load     = 1'b0;
    load_val = CW'(CLK_DIV - 1);
    unique case (state_q)
      S_IDLE: if (start) begin
        state_d = S_SETUP;
        load    = 1'b1;
        bit_d   = '0;
      end
      S_SETUP: if (tick) begin
        state_d = S_HI;
        load    = 1'b1;
      end
      S_HI: if (tick) begin
        state_d = S_LO;
        load    = 1'b1;
      end
      S_LO: if (tick) begin
        load = 1'b1;
        if (bit_q == LAST) begin
          state_d  = S_GAP;
          load_val = CW'(CLK_DIV);
        end else begin
          state_d = S_HI;
          bit_d   = bit_q + 5'd1;
        end
      end
      S_GAP: if (tick) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // GAP is one cycle longer so done lands after cs_n has been high CLK_DIV cycles
    if (abort_hit) begin
      state_d  = S_GAP;
      load     = 1'b1;
      load_val = CW'(CLK_DIV);
    end
  end

  assign rx_hit = (state_d == S_HI) && (state_q != S_HI) &&
    (bit_d >= 5'(RX_FIRST_BIT)) && (bit_d <= 5'(RX_LAST_BIT));
  assign rx_idx = 3'(5'(RX_LAST_BIT) - bit_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tx_q    <= '0;
      bit_q   <= '0;
      mosi_q  <= 1'b0;
      rx_q    <= '0;
      done_q  <= 1'b0;
`ifdef NPU_SPI_ABORT_EN
      ab_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      done_q  <= (state_q == S_GAP) && (state_d == S_IDLE);
      if (accept) begin
        tx_q   <= frame;
        mosi_q <= frame[FRAME_BITS-1];
        rx_q   <= '0;
`ifdef NPU_SPI_ABORT_EN
        ab_q   <= 1'b0;
`endif
      end
      if (rx_hit) rx_q[rx_idx] <= miso;
      if (state_q == S_HI && state_d == S_LO && bit_q != LAST) begin
        mosi_q <= tx_q[FRAME_BITS-2];
        tx_q   <= {tx_q[FRAME_BITS-2:0], 1'b0};
      end
      if (state_d == S_GAP) mosi_q <= 1'b0;
`ifdef NPU_SPI_ABORT_EN
      if (abort_hit) ab_q <= 1'b1;
`endif
    end
  end

  assign ready   = (state_q == S_IDLE);
  assign cs_n    = (state_q == S_IDLE) || (state_q == S_GAP);
  assign sclk    = (state_q == S_HI);
  assign mosi    = mosi_q;
  assign done    = done_q;
  assign rx_data = rx_q;

endmodule
